alu_issue_ctrl: RTL

Command-side initiator for the 32-bit combinational ALU. It accepts operation requests over a valid/ready handshake, encodes the opcode into the ALU's 3-bit select, and drives operands and enable for a fixed number of cycles. It then captures the ALU output and returns the result over a second valid/ready handshake. It sits between the instruction/control path and the ALU datapath, and is the only driver of the ALU's `a`, `b`, `sel` and `enable` inputs.

---
 rtl/alu_issue_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command-side initiator for the 32-bit combinational ALU.
// Accepts an op request, drives the ALU operands/select/enable for the
// op's cycle count, captures the ALU output and returns it as a response.
// Optional feature macro: ALU_ISSUE_ERRCNT_EN adds a saturating count of
// accepted illegal-opcode commands on the err_count output.
module alu_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
`ifdef ALU_ISSUE_ERRCNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_NAND = 3'b100;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SUB  = 3'b011;
    localparam logic [2:0] SEL_MUL  = 3'b111;

    // MUL spends one cycle in ISSUE and MUL_CYCLES-1 in WAIT; the counter
    // is loaded with the number of WAIT cycles minus one.
    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
    localparam int         WAIT_CYC  = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

    // Returns {legal, select}; illegal opcodes map to a zero select that is
    // never loaded into the operand registers.
    function automatic logic [3:0] encode_op(input logic [2:0] op);
        case (op)
            3'd0:    return {1'b1, SEL_AND};
            3'd1:    return {1'b1, SEL_OR};
            3'd2:    return {1'b1, SEL_NAND};
            3'd3:    return {1'b1, SEL_ADD};
            3'd4:    return {1'b1, SEL_SUB};
            3'd5:    return {1'b1, SEL_MUL};
            default: return {1'b0, 3'b000};
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         enc_op;
    logic               illegal_acc;

    assign enc_op      = encode_op(cmd_op);
    assign illegal_acc = (state_q == IDLE) && cmd_valid && !enc_op[3];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, select, counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= SEL_AND;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state and datapath-load decisions.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (enc_op[3]) begin
                        a_d     = cmd_a;
                        b_d     = cmd_b;
                        sel_d   = enc_op[2:0];
                        state_d = ISSUE;
                    end else begin
                        // Illegal op: answer directly, ALU untouched.
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (MUL_MULTI && (sel_q == SEL_MUL)) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end else begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign alu_enable = (state_q == ISSUE) || (state_q == WAIT);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;

`ifdef ALU_ISSUE_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of accepted illegal-opcode commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (illegal_acc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_acc;
`endif

endmodule
